// File: rtl/inst_sram_responder.sv
// Single-port synchronous SRAM responder with a fixed one-cycle read latency.
// Read data holds until the next legal or illegal read. Also keeps a sticky
// address-error flag and read/write access counters for debug.
module inst_sram_responder #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h1C00_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sram_en,
    input  logic [3:0]  sram_wen,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    output logic        oob_err,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);

    localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
    localparam int unsigned LANES     = 4;
    localparam logic [32:0] DEPTH_LIM = 33'(1) << ADDR_WIDTH;

    // Memory array; contents intentionally survive reset.
    logic [31:0] mem [DEPTH];

    logic [31:0]           off;
    logic [ADDR_WIDTH-1:0] index;
    logic                  in_range;
    logic                  aligned;
    logic                  legal;
    logic                  is_write;
    logic                  do_read;
    logic                  do_write;
    logic                  bad_req;

    // Address decode relative to the base, with 32-bit wrap arithmetic.
    always_comb begin
        off      = sram_addr - BASE_ADDR;
        index    = off[ADDR_WIDTH+1:2];
        in_range = (33'(off >> 2) < DEPTH_LIM);
        aligned  = (sram_addr[1:0] == 2'b00);
        legal    = in_range && aligned;
        is_write = (sram_wen != 4'b0000);
        do_read  = sram_en && !is_write && legal && !reset;
        do_write = sram_en &&  is_write && legal && !reset;
        bad_req  = sram_en && !legal;
    end

    // Byte-lane writes; a request coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (do_write && sram_wen[i]) begin
                mem[index][8*i +: 8] <= sram_wdata[8*i +: 8];
            end
        end
    end

    // Read data register: loads on legal reads, clears on illegal reads, else holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            sram_rdata <= 32'h0;
        end else if (do_read) begin
            sram_rdata <= mem[index];
        end else if (bad_req && !is_write) begin
            sram_rdata <= 32'h0;
        end
    end

    // Sticky address-error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            oob_err <= 1'b0;
        end else if (bad_req) begin
            oob_err <= 1'b1;
        end
    end

    // Accepted-access counters; wrap silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count <= 32'h0;
            wr_count <= 32'h0;
        end else begin
            if (do_read) begin
                rd_count <= rd_count + 32'd1;
            end
            if (do_write) begin
                wr_count <= wr_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_inst_sram_responder.sv
// Directed self-checking bench for inst_sram_responder.
module tb_inst_sram_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        oob_err;
    logic [31:0] rd_count;
    logic [31:0] wr_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_sram_responder dut (
        .clk        (clk),
        .reset      (reset),
        .sram_en    (sram_en),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .oob_err    (oob_err),
        .rd_count   (rd_count),
        .wr_count   (wr_count)
    );

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_oob;
        logic [31:0] exp_rd;
        logic [31:0] exp_wr;
    } vec_t;

    localparam int NVEC     = 23;
    localparam int STALL_AT = 11;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic en, input logic [3:0] wen,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_oob,
                                input logic [31:0] exp_rd, input logic [31:0] exp_wr);
        vec_t v;
        v.en = en; v.wen = wen; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_oob = exp_oob;
        v.exp_rd = exp_rd; v.exp_wr = exp_wr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_rdata, input logic e_oob,
                             input logic [31:0] e_rd, input logic [31:0] e_wr);
        check({tag, ".rdata"}, sram_rdata, e_rdata);
        check({tag, ".oob"}, 32'(oob_err), 32'(e_oob));
        check({tag, ".rd_count"}, rd_count, e_rd);
        check({tag, ".wr_count"}, wr_count, e_wr);
    endtask

    task automatic drive(input logic en, input logic [3:0] wen,
                         input logic [31:0] addr, input logic [31:0] wdata);
        sram_en = en; sram_wen = wen; sram_addr = addr; sram_wdata = wdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Legal traffic, stall hold point at STALL_AT, then illegal accesses.
        vecs[0]  = mk(1, 4'hF, 32'h1C00_0010, 32'hDEAD_BEEF, 32'h0000_0000, 0, 0, 1);
        vecs[1]  = mk(1, 4'h0, 32'h1C00_0010, 32'h0,         32'hDEAD_BEEF, 0, 1, 1);
        vecs[2]  = mk(1, 4'hF, 32'h1C00_0020, 32'h1122_3344, 32'hDEAD_BEEF, 0, 1, 2);
        vecs[3]  = mk(1, 4'h5, 32'h1C00_0020, 32'hAABB_CCDD, 32'hDEAD_BEEF, 0, 1, 3);
        vecs[4]  = mk(1, 4'h0, 32'h1C00_0020, 32'h0,         32'h11BB_33DD, 0, 2, 3);
        vecs[5]  = mk(1, 4'hF, 32'h1C00_0000, 32'h0280_0000, 32'h11BB_33DD, 0, 2, 4);
        vecs[6]  = mk(1, 4'hF, 32'h1C00_0004, 32'h0290_0000, 32'h11BB_33DD, 0, 2, 5);
        vecs[7]  = mk(1, 4'hF, 32'h1C00_0008, 32'h02A0_0000, 32'h11BB_33DD, 0, 2, 6);
        vecs[8]  = mk(1, 4'hF, 32'h1C00_0040, 32'h1357_9BDF, 32'h11BB_33DD, 0, 2, 7);
        vecs[9]  = mk(1, 4'hF, 32'h1C03_FFFC, 32'h0BAD_C0DE, 32'h11BB_33DD, 0, 2, 8);
        vecs[10] = mk(1, 4'h0, 32'h1C00_0000, 32'h0,         32'h0280_0000, 0, 3, 8);
        vecs[11] = mk(1, 4'h0, 32'h1C00_0000, 32'h0,         32'h0280_0000, 0, 4, 8);
        vecs[12] = mk(1, 4'h0, 32'h1C00_0004, 32'h0,         32'h0290_0000, 0, 5, 8);
        vecs[13] = mk(1, 4'h0, 32'h1C00_0008, 32'h0,         32'h02A0_0000, 0, 6, 8);
        vecs[14] = mk(1, 4'h0, 32'h1C03_FFFC, 32'h0,         32'h0BAD_C0DE, 0, 7, 8);
        vecs[15] = mk(1, 4'h0, 32'h1BFF_FFFC, 32'h0,         32'h0000_0000, 1, 7, 8);
        vecs[16] = mk(1, 4'hF, 32'h1C00_0002, 32'h1234_5678, 32'h0000_0000, 1, 7, 8);
        vecs[17] = mk(1, 4'h0, 32'h1C00_0000, 32'h0,         32'h0280_0000, 1, 8, 8);
        vecs[18] = mk(1, 4'h0, 32'h1C04_0000, 32'h0,         32'h0000_0000, 1, 8, 8);
        vecs[19] = mk(1, 4'hF, 32'h1C04_0000, 32'h5555_5555, 32'h0000_0000, 1, 8, 8);
        vecs[20] = mk(1, 4'h0, 32'h1C00_0004, 32'h0,         32'h0290_0000, 1, 9, 8);
        vecs[21] = mk(1, 4'h0, 32'h1C00_0005, 32'h0,         32'h0000_0000, 1, 9, 8);
        vecs[22] = mk(1, 4'h0, 32'h1C00_0000, 32'h0,         32'h0280_0000, 1, 10, 8);

        // Reset for 3 cycles, then idle for 5.
        reset = 1'b1;
        drive(0, 4'h0, 32'h0, 32'h0);
        repeat (3) tick();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_all($sformatf("idle%0d", c), 32'h0, 1'b0, 32'h0, 32'h0);
        end

        for (int i = 0; i < NVEC; i++) begin
            if (i == STALL_AT) begin
                // Stall: en low with garbage on the other inputs must hold everything.
                for (int s = 0; s < 10; s++) begin
                    drive(0, 4'($urandom_range(15)), $urandom, $urandom);
                    tick();
                    check_all($sformatf("stall%0d", s), 32'h0280_0000, 1'b0, 32'd3, 32'd8);
                end
            end
            drive(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].exp_rdata, vecs[i].exp_oob,
                      vecs[i].exp_rd, vecs[i].exp_wr);
        end

        // Reset coinciding with a write: write dropped, state cleared.
        reset = 1'b1;
        drive(1, 4'hF, 32'h1C00_0040, 32'hCAFE_F00D);
        tick();
        check_all("rst_wr", 32'h0, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        drive(1, 4'h0, 32'h1C00_0040, 32'h0);
        tick();
        check_all("post_rst_rd", 32'h1357_9BDF, 1'b0, 32'd1, 32'd0);
        drive(0, 4'h0, 32'h0, 32'h0);
        tick();
        check_all("post_rst_hold", 32'h1357_9BDF, 1'b0, 32'd1, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
